// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver_if
// Description : Bundle between a display-value source and the 7-segment
//               scan driver.
//               master : drives en, data, dp_in; observes num, seg
//               slave  : the scan driver; consumes en, data, dp_in and
//                        produces num (digit index) and seg (active-low
//                        segments, seg[7] = dp)
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_driver_if;
    logic        en;     // scan enable
    logic [31:0] data;   // nibble k shown on digit k
    logic [7:0]  dp_in;  // decimal point per digit, active-high
    logic [2:0]  num;    // current digit index to the digit-select decoder
    logic [7:0]  seg;    // active-low {dp,g,f,e,d,c,b,a}

    modport master (
        output en,
        output data,
        output dp_in,
        input  num,
        input  seg
    );

    modport slave (
        input  en,
        input  data,
        input  dp_in,
        output num,
        output seg
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed scan controller for an 8-digit hex
//               7-segment display. Steps a 3-bit digit index every DIV
//               enabled cycles and drives the matching active-low segment
//               pattern. The 32-bit display value and decimal points are
//               snapshotted once per frame (on the 7 -> 0 wrap) so a
//               frame never shows a mix of old and new data.
//
// Ports       : clk      system clock, rising edge
//               rst      asynchronous active-high reset
//               bus      seg_scan_driver_if.slave
//                          en    scan enable (low freezes all state)
//                          data  display value, nibble k on digit k
//                          dp_in decimal point per digit
//                          num   registered digit index
//                          seg   registered active-low {dp,g..a}
//
// Parameters  : DIV      enabled clock cycles per digit slot (2..2^24)
//               CW       prescaler width; DIV-1 must fit in CW bits
//
// Build macro : SEG_SCAN_LEADING_ZERO_BLANK_EN
//               When defined, digits above the most significant nonzero
//               nibble of the snapshot are blanked (dp still shown).
//               Digit 0 is never blanked.
//
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int DIV = 100000,
    parameter int CW  = 24
) (
    input  wire              clk,
    input  wire              rst,
    seg_scan_driver_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [CW-1:0] c_cnt_last  = CW'(DIV - 1);
    localparam logic [2:0]    c_last_dig  = 3'd7;
    localparam logic [7:0]    c_seg_reset = 8'hC0;  // glyph "0", dp off

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_num;
    logic [31:0]   r_snap_data;
    logic [7:0]    r_snap_dp;
    logic [7:0]    r_seg;

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    logic          w_tick;
    logic          w_frame_wrap;
    logic [2:0]    w_num_nxt;
    logic [31:0]   w_snap_data_nxt;
    logic [7:0]    w_snap_dp_nxt;
    logic [7:0]    w_seg_nxt;

    // ------------------------------------------------------------------------
    // Font: hex nibble to active-high {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_font(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    // Index of the most significant nonzero nibble; 0 when the value is
    // zero so that digit 0 always stays lit.
    function automatic logic [2:0] f_top_digit(input logic [31:0] d);
        logic [2:0] top;
        top = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (d[4*i +: 4] != 4'h0) begin
                top = 3'(i);
            end
        end
        return top;
    endfunction
`endif

    // Segment pattern for digit k of a given snapshot, active-low.
    function automatic logic [7:0] f_seg(
        input logic [31:0] d,
        input logic [7:0]  dp,
        input logic [2:0]  k
    );
        logic [3:0] nib;
        logic [6:0] glyph;
        nib   = d[{k, 2'b00} +: 4];
        glyph = f_font(nib);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        if (k > f_top_digit(d)) begin
            glyph = 7'h00;
        end
`endif
        return ~{dp[k], glyph};
    endfunction

    // ------------------------------------------------------------------------
    // Next-state logic. seg is built from the next-state snapshot and the
    // next-state digit index so num and seg move on the same edge and the
    // first digit of a new frame already shows the freshly loaded value.
    // ------------------------------------------------------------------------
    always_comb begin
        w_tick          = bus.en && (r_cnt == c_cnt_last);
        w_frame_wrap    = w_tick && (r_num == c_last_dig);
        w_num_nxt       = r_num;
        w_snap_data_nxt = r_snap_data;
        w_snap_dp_nxt   = r_snap_dp;

        if (w_tick) begin
            w_num_nxt = 3'(r_num + 3'd1);
        end
        if (w_frame_wrap) begin
            w_snap_data_nxt = bus.data;
            w_snap_dp_nxt   = bus.dp_in;
        end

        w_seg_nxt = f_seg(w_snap_data_nxt, w_snap_dp_nxt, w_num_nxt);
    end

    // ------------------------------------------------------------------------
    // Registers. Only a tick can change num or the snapshot, so seg is
    // loaded on ticks only; between ticks it already equals its next value.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_num       <= 3'd0;
            r_snap_data <= 32'h0;
            r_snap_dp   <= 8'h0;
            r_seg       <= c_seg_reset;
        end else begin
            if (bus.en) begin
                if (r_cnt == c_cnt_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_tick) begin
                r_num       <= w_num_nxt;
                r_snap_data <= w_snap_data_nxt;
                r_snap_dp   <= w_snap_dp_nxt;
                r_seg       <= w_seg_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.num = r_num;
    assign bus.seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Self-checking bench for seg_scan_driver with DIV=4.
//               A frame-level model (enabled-cycle count, snapshot taken
//               at each multiple of 8*DIV) predicts num and seg every
//               cycle; directed literal expectations pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int c_div   = 4;
    localparam int c_frame = 8 * c_div;

    logic clk;
    logic rst;

    seg_scan_driver_if sif();

    seg_scan_driver #(
        .DIV (c_div),
        .CW  (24)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Font table, active-high {g..a}
    logic [6:0] c_font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Hand-computed literal expectations
    logic [7:0] c_lit_a [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    logic [7:0] c_lit_b [8] = '{8'h00, 8'hF8, 8'h02, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [7:0] c_lit_c [8] = '{8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] c_lit_d [8] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    logic [7:0] c_lit_c [8] = '{8'hC0, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    logic [7:0] c_lit_d [8] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: counts enabled edges since reset; the digit shown is
    // (count / DIV) mod 8 and the snapshot is reloaded whenever the count
    // reaches a whole number of frames.
    // ------------------------------------------------------------------------
    int unsigned m_ecnt;
    logic [31:0] m_data;
    logic [7:0]  m_dp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ecnt = 0;
            m_data = 32'h0;
            m_dp   = 8'h0;
        end else if (sif.en) begin
            m_ecnt = m_ecnt + 1;
            if (m_ecnt % c_frame == 0) begin
                m_data = sif.data;
                m_dp   = sif.dp_in;
            end
        end
    end

    function automatic logic [7:0] model_seg(input logic [31:0] d, input logic [7:0] dp, input int k);
        logic [6:0] g;
        int top;
        g = c_font[(d >> (4 * k)) & 32'hF];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        top = 0;
        for (int i = 0; i < 8; i++) begin
            if (((d >> (4 * i)) & 32'hF) != 0) top = i;
        end
        if (k > top) g = 7'h00;
`else
        top = 0;
`endif
        return ~{dp[k], g};
    endfunction

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("scan_num", {29'b0, sif.num}, (m_ecnt / c_div) % 8);
            chk("scan_seg", {24'b0, sif.seg},
                {24'b0, model_seg(m_data, m_dp, int'((m_ecnt / c_div) % 8))});
        end
    end

    // Inputs change 2 time units after a rising edge
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst       = 1'b1;
        sif.en    = 1'b0;
        sif.data  = 32'h0;
        sif.dp_in = 8'h0;
        adv(2);
        rst = 1'b0;
        chk("reset_num", {29'b0, sif.num}, 32'd0);
        chk("reset_seg", {24'b0, sif.seg}, 32'hC0);
        sif.en = 1'b1;

        // First frame shows zeros; new data lands at the wrap
        adv(20);
        sif.data = 32'h89ABCDEF;
        adv(12);
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("snap_num%0d", d), {29'b0, sif.num}, d);
            chk($sformatf("snap_seg%0d", d), {24'b0, sif.seg}, {24'b0, c_lit_a[d]});
            adv(c_div);
        end

        // Mid-frame change must not show until the next wrap
        sif.data  = 32'h12345678;
        sif.dp_in = 8'h05;
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("hold_seg%0d", d), {24'b0, sif.seg}, {24'b0, c_lit_a[d]});
            adv(c_div);
        end
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("new_seg%0d", d), {24'b0, sif.seg}, {24'b0, c_lit_b[d]});
            chk($sformatf("dp_bit%0d", d), {31'b0, sif.seg[7]}, (d == 0 || d == 2) ? 32'd0 : 32'd1);
            adv(c_div);
        end

        // Freeze during digit 3 with cnt=2
        adv(3 * c_div + 2);
        sif.en = 1'b0;
        chk("frz_num_a", {29'b0, sif.num}, 32'd3);
        chk("frz_seg_a", {24'b0, sif.seg}, 32'h92);
        adv(10);
        chk("frz_num_b", {29'b0, sif.num}, 32'd3);
        chk("frz_seg_b", {24'b0, sif.seg}, 32'h92);
        sif.en = 1'b1;
        adv(1);
        chk("resume_num1", {29'b0, sif.num}, 32'd3);
        adv(1);
        chk("resume_num2", {29'b0, sif.num}, 32'd4);
        chk("resume_seg2", {24'b0, sif.seg}, 32'h99);

        // Asynchronous reset while digit 5 is shown
        adv(c_div);
        chk("pre_rst_num", {29'b0, sif.num}, 32'd5);
        rst = 1'b1;
        #1;
        chk("arst_num", {29'b0, sif.num}, 32'd0);
        chk("arst_seg", {24'b0, sif.seg}, 32'hC0);
        @(posedge clk);
        #2;
        rst       = 1'b0;
        sif.data  = 32'h000000A0;
        sif.dp_in = 8'h00;
        chk("post_rst_seg", {24'b0, sif.seg}, 32'hC0);

        // Leading-zero behaviour
        adv(c_frame);
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("lz_a_seg%0d", d), {24'b0, sif.seg}, {24'b0, c_lit_c[d]});
            adv(c_div);
        end
        sif.data = 32'h0;
        adv(c_frame);
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("lz_z_seg%0d", d), {24'b0, sif.seg}, {24'b0, c_lit_d[d]});
            adv(c_div);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed scan controller for the 8-digit hex 7-segment display.
- Sits directly upstream of the 3-to-8 digit-select decoder: drives the decoder's 3-bit digit index `num`, plus the matching active-low segment pattern for that digit.
- Snapshots a 32-bit display value once per frame so digits never tear mid-scan.

Parameters:
- DIV, 100000: enabled clock cycles per digit slot; legal range 2..2^24; 4 in simulation.
- CW, 24: prescaler counter width; DIV-1 must fit in CW bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; low freezes prescaler, num, snapshot and seg.
- data  input  32  display value; nibble k (data[4k+3:4k]) shown on digit k.
- dp_in  input  8  decimal point per digit; bit k high lights dp on digit k.
- num  output  3  current digit index, registered; feeds the digit-select decoder.
- seg  output  8  active-low segments, registered: seg[6:0] = g,f,e,d,c,b,a; seg[7] = dp.

Behaviour:
- Reset (async, rst=1) values:
  - prescaler cnt=0, num=0
  - snapshot snap_data=0, snap_dp=0
  - seg=8'hC0 (digit "0", dp off).
- Prescaler:
  - If en=1: cnt increments each clk and wraps DIV-1 -> 0.
  - tick = en & (cnt==DIV-1), combinational and internal.
  - If en=0: cnt holds.
- Digit index:
  - On tick, num <= num+1 mod 8 (7 -> 0 wraps).
  - Otherwise num holds.
  - Each digit is therefore held for exactly DIV enabled cycles.
- Frame snapshot:
  - On tick with num==7, load snap_data <= data and snap_dp <= dp_in in the same edge that num wraps to 0.
  - data and dp_in are ignored at all other times.
  - After reset the first frame shows all zeros; new data appears from the first wrap onward.
- Segment output:
  - seg is registered in the same edge as num, so both change together; there is no cycle of mismatch.
  - seg <= ~{dp_bit, font(nibble)}, where nibble and dp_bit are taken from the next-state snapshot at the next-state num.
  - On a frame wrap, digit 0 of the new frame uses the freshly loaded data.
- Font (active-high, bits g..a):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Latency: a change on data is visible on seg no later than 8*DIV enabled cycles plus 1 edge after it is applied, i.e. at the next frame wrap.
- en deasserted mid-digit: all state holds. On re-enable, counting resumes from the held cnt with no skipped or repeated digit.
- rst asserted mid-frame: immediate return to the reset values regardless of clk.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most significant nonzero nibble of snap_data show seg[6:0]=7'h7F (all off).
  - dp for a blanked digit still follows snap_dp.
  - Digit 0 is never blanked; snap_data=0 shows a single "0".
  - Blank mask is derived from the next-state snapshot, consistent with the seg timing above.
- Undefined: every digit always shows its hex glyph, including leading zeros.

Test Plan:
- Reset and scan: DIV=4, rst pulse, en=1, data=32'h0 -> seg=8'hC0 on all digits; num steps 0,1,...,7,0 every 4 clks; num and seg change on the same edge.
- Snapshot: data=32'h89ABCDEF before the first wrap -> from the wrap, digits 0..7 show seg = 8E, 86, A1, C6, 83, 88, 90, 80.
  - Change data to 32'h12345678 mid-frame -> no digit changes until the next 7 -> 0 wrap.
- Decimal point: dp_in=8'h05 latched -> digits 0 and 2 have seg[7]=0; all other digits have seg[7]=1.
- Enable freeze: drop en for 10 clks during digit 3 with cnt=2 -> num, seg and cnt are frozen.
  - On re-enable, num advances to 4 after exactly 2 enabled clks.
- Async reset mid-frame: assert rst between clock edges while num=5 -> num=0 and seg=8'hC0 immediately, before the next clk edge.
- Blanking (macro defined): data=32'h000000A0 -> digits 2..7 seg=8'hFF, digit 1 seg=8'h88, digit 0 seg=8'hC0.
  - data=0 -> only digit 0 lit, showing "0".
